// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads one opcode byte and up to two operand bytes
// from a byte-wide memory, then presents the assembled instruction to the
// decoder. Instruction length comes from bits [7:6] of the opcode byte.
//
// Handshakes:
//   memory : mem_rd is held high for the whole FETCH state with mem_addr
//            equal to pc_addr; each cycle with mem_ack=1 delivers exactly one
//            byte and pulses pc_inc so the external PC moves to the next byte.
//   decoder: instr_valid/instr_ready; a transfer happens on a rising edge where
//            both are high. While valid is high without ready, every instr_*
//            output holds its value.
//   flush  : overrides everything else, drops the in-flight instruction and
//            returns to IDLE.
`timescale 1ns/1ps

module instruction_fetch #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_opcode,
    output logic [DATA_W-1:0] instr_op1,
    output logic [DATA_W-1:0] instr_op2,
    output logic [1:0]        instr_len,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [1:0]        dbg_state
);

    // State encoding, also visible on dbg_state.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;

    // Index of the byte slot the next acknowledged read fills (0..2).
    logic [1:0] byte_idx;

    // Length decoded from the byte currently on mem_data (meaningful for byte 0).
    logic [1:0] dec_len;

    // Length in force for the byte being captured: the freshly decoded one
    // for the opcode byte, the latched one for operand bytes.
    logic [1:0] eff_len;

    // The byte being captured this cycle completes the instruction.
    logic       last_byte;

    // A byte is actually taken this cycle (flush suppresses the capture).
    logic       capture;

    // Decode the instruction length from the top two opcode bits.
    always_comb begin
        dec_len = 2'd1;
        case (mem_data[7:6])
            2'b01:   dec_len = 2'd2;
            2'b10:   dec_len = 2'd3;
            default: dec_len = 2'd1;
        endcase
    end

    // Work out whether the current byte finishes the instruction.
    always_comb begin
        eff_len   = (byte_idx == 2'd0) ? dec_len : instr_len;
        last_byte = ((byte_idx + 2'd1) == eff_len);
        capture   = (state == S_FETCH) && mem_ack && !flush;
    end

    // State register; reset forces IDLE immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush wins over acknowledge and ready.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fetch_en) begin
                        state_next = S_FETCH;
                    end
                end
                S_FETCH: begin
                    // fetch_en is ignored here: an started instruction always completes.
                    if (mem_ack && last_byte) begin
                        state_next = S_OUT;
                    end
                end
                S_OUT: begin
                    // Going straight to FETCH avoids a bubble between instructions.
                    if (instr_ready) begin
                        state_next = fetch_en ? S_FETCH : S_IDLE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        mem_rd      = 1'b0;
        mem_addr    = '0;
        pc_inc      = 1'b0;
        instr_valid = 1'b0;
        dbg_state   = state;
        case (state)
            S_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = pc_addr;
                pc_inc   = capture;
            end
            S_OUT: begin
                instr_valid = 1'b1;
            end
            default: begin
                mem_rd = 1'b0;
            end
        endcase
    end

    // Byte slots, length, opcode address and byte index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx     <= 2'd0;
            instr_opcode <= '0;
            instr_op1    <= '0;
            instr_op2    <= '0;
            instr_len    <= 2'd0;
            instr_pc     <= '0;
        end else if (flush) begin
            // The partial instruction is abandoned; the next one starts at byte 0.
            byte_idx <= 2'd0;
        end else if (capture) begin
            case (byte_idx)
                2'd0: begin
                    // Operand slots are cleared so short instructions read 0 there.
                    instr_opcode <= mem_data;
                    instr_op1    <= '0;
                    instr_op2    <= '0;
                    instr_len    <= dec_len;
                    instr_pc     <= pc_addr;
                end
                2'd1: begin
                    instr_op1 <= mem_data;
                end
                default: begin
                    instr_op2 <= mem_data;
                end
            endcase
            byte_idx <= last_byte ? 2'd0 : (byte_idx + 2'd1);
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a memory/PC model answers reads with
// programmable wait states, a scoreboard queue holds the instructions the
// decoder should receive, and directed plus random scenarios drive the unit.
`timescale 1ns/1ps

module tb_instruction_fetch;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic              clk;
  logic              reset;
  logic              fetch_en;
  logic              flush;
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_inc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_opcode;
  logic [DATA_W-1:0] instr_op1;
  logic [DATA_W-1:0] instr_op2;
  logic [1:0]        instr_len;
  logic [ADDR_W-1:0] instr_pc;
  logic [1:0]        dbg_state;

  instruction_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_en     (fetch_en),
    .flush        (flush),
    .pc_addr      (pc_addr),
    .pc_inc       (pc_inc),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_op1    (instr_op1),
    .instr_op2    (instr_op2),
    .instr_len    (instr_len),
    .instr_pc     (instr_pc),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- shared state ----------------
  logic [7:0]  mem [0:65535];
  logic [41:0] exp_q[$];   // {opcode, op1, op2, len, pc}
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pc_inc = 0;
  int          n_accept = 0;
  logic        cfg_fetch_en = 1'b0;
  logic        cfg_flush    = 1'b0;
  logic        cfg_ready    = 1'b0;
  int          cfg_waits    = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_instr(input string tag, input logic [41:0] e);
    check({tag, "_opcode"}, instr_opcode, e[41:34]);
    check({tag, "_op1"},    instr_op1,    e[33:26]);
    check({tag, "_op2"},    instr_op2,    e[25:18]);
    check({tag, "_len"},    instr_len,    e[17:16]);
    check({tag, "_pc"},     instr_pc,     e[15:0]);
  endtask

  // ---------------- memory / PC model and scoreboard ----------------
  // Inputs change at the falling edge; outputs are sampled 2 ns later.
  initial begin : bus_model
    int          wait_cnt;
    logic        last_inc;
    logic [41:0] e;
    wait_cnt = 0;
    last_inc = 1'b0;
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    fetch_en = 1'b0;
    flush    = 1'b0;
    instr_ready = 1'b0;
    forever begin
      @(negedge clk);
      fetch_en    = cfg_fetch_en;
      flush       = cfg_flush;
      instr_ready = cfg_ready;
      if (reset) begin
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        wait_cnt = 0;
        last_inc = 1'b0;
      end else begin
        if (last_inc) pc_addr = pc_addr + 16'd1;
        #1;
        if (mem_rd) begin
          check("mem_addr", mem_addr, pc_addr);
          if (wait_cnt < cfg_waits) begin
            mem_ack  = 1'b0;
            mem_data = 8'($urandom_range(0, 255));
            wait_cnt++;
          end else begin
            mem_ack  = 1'b1;
            mem_data = mem[mem_addr];
            wait_cnt = 0;
          end
        end else begin
          check("mem_addr_idle", mem_addr, 0);
          mem_ack  = 1'b0;
          mem_data = 8'($urandom_range(0, 255));
          wait_cnt = 0;
        end
        #1;
        last_inc = pc_inc;
        if (pc_inc) n_pc_inc++;
        if (instr_valid && instr_ready && !flush) begin
          n_accept++;
          if (exp_q.size() == 0) begin
            check("unexpected_instr", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_instr("sb", e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_for_rd();
    int t = 0;
    while (!mem_rd && t < 50) begin cyc(); t++; end
    check("fetch_start_timeout", mem_rd, 1);
  endtask

  task automatic wait_for_valid(output int cycles);
    cycles = 0;
    while (!instr_valid && cycles < 100) begin cyc(); cycles++; end
    check("valid_timeout", instr_valid, 1);
  endtask

  task automatic wait_accepts(input int target);
    int t = 0;
    while (n_accept < target && t < 100) begin cyc(); t++; end
    check("accept_timeout", (n_accept >= target) ? 1 : 0, 1);
  endtask

  // Place an instruction in memory, point the PC at it and optionally
  // expect it at the decoder.
  task automatic load_instr(input logic [15:0] pc, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input bit push, output int len);
    logic [15:0] a1, a2;
    logic [7:0]  o1, o2;
    logic [1:0]  l2;
    a1 = pc + 16'd1;
    a2 = pc + 16'd2;
    mem[pc] = b0;
    mem[a1] = b1;
    mem[a2] = b2;
    if (b0[7:6] == 2'b01)      len = 2;
    else if (b0[7:6] == 2'b10) len = 3;
    else                       len = 1;
    o1 = (len >= 2) ? b1 : 8'h00;
    o2 = (len == 3) ? b2 : 8'h00;
    l2 = 2'(len);
    if (push) exp_q.push_back({b0, o1, o2, l2, pc});
    pc_addr = pc;
  endtask

  // One full instruction with the decoder always ready.
  task automatic run_instr(input logic [15:0] pc, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int waits);
    int len, base_inc, base_acc, lat;
    logic [15:0] pc_end;
    load_instr(pc, b0, b1, b2, 1'b1, len);
    cfg_waits = waits;
    base_inc  = n_pc_inc;
    base_acc  = n_accept;
    cfg_ready = 1'b1;
    cfg_fetch_en = 1'b1;
    wait_for_rd();
    cfg_fetch_en = 1'b0;
    wait_for_valid(lat);
    if (waits == 0) check("latency", lat, len);
    wait_accepts(base_acc + 1);
    pc_end = pc + 16'(len);
    check("pc_inc_count", n_pc_inc - base_inc, len);
    check("pc_after", pc_addr, pc_end);
    cyc();
    check("idle_after", dbg_state, ST_IDLE);
    check("valid_after", instr_valid, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int len, lat, base_inc, base_acc;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    pc_addr = 16'h0000;
    reset = 1'b1;
    repeat (3) cyc();

    // Reset state
    check("rst_valid",  instr_valid, 0);
    check("rst_pc_inc", pc_inc, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_opcode", instr_opcode, 0);
    check("rst_len",    instr_len, 0);
    check("rst_pc",     instr_pc, 0);
    check("rst_state",  dbg_state, ST_IDLE);
    reset = 1'b0;
    cyc();
    check("idle_no_fetch", mem_rd, 0);

    // Single-byte, three-byte with wait states, and the 11 length code
    run_instr(16'h0010, 8'h05, 8'hEE, 8'hDD, 0);
    run_instr(16'h0100, 8'h80, 8'h34, 8'h12, 2);
    run_instr(16'h0150, 8'hC3, 8'h11, 8'h22, 1);

    // Backpressure, then a back-to-back fetch with no bubble
    load_instr(16'h0200, 8'h47, 8'hAA, 8'h00, 1'b1, len);
    cfg_waits = 1;
    cfg_ready = 1'b0;
    cfg_fetch_en = 1'b1;
    base_acc = n_accept;
    wait_for_rd();
    cfg_fetch_en = 1'b0;
    wait_for_valid(lat);
    base_inc = n_pc_inc;
    repeat (5) begin
      cyc();
      check("bp_valid",  instr_valid, 1);
      check("bp_mem_rd", mem_rd, 0);
      check("bp_pc_inc", pc_inc, 0);
      check_instr("bp", exp_q[0]);
    end
    check("bp_no_inc", n_pc_inc - base_inc, 0);
    check("bp_pc", pc_addr, 16'h0202);
    load_instr(16'h0202, 8'h03, 8'h00, 8'h00, 1'b1, len);
    cfg_ready = 1'b1;
    cfg_fetch_en = 1'b1;
    cyc();
    cyc();
    check("b2b_state", dbg_state, ST_FETCH);
    check("b2b_mem_rd", mem_rd, 1);
    cfg_fetch_en = 1'b0;
    wait_accepts(base_acc + 2);
    cyc();

    // Flush on the operand acknowledge of a 2-byte instruction
    load_instr(16'h0300, 8'h40, 8'h99, 8'h00, 1'b0, len);
    cfg_waits = 0;
    cfg_fetch_en = 1'b1;
    wait_for_rd();
    check("fl_b0_inc", pc_inc, 1);
    cfg_fetch_en = 1'b0;
    cfg_flush = 1'b1;
    cyc();
    check("fl_ack_present", mem_ack, 1);
    check("fl_pc_inc", pc_inc, 0);
    cfg_flush = 1'b0;
    cyc();
    check("fl_idle", dbg_state, ST_IDLE);
    check("fl_valid", instr_valid, 0);
    check("fl_pc", pc_addr, 16'h0301);
    run_instr(16'h0300, 8'h40, 8'h99, 8'h00, 0);

    // Flush while presenting beats a simultaneous ready
    load_instr(16'h0600, 8'h01, 8'h00, 8'h00, 1'b1, len);
    cfg_ready = 1'b0;
    cfg_fetch_en = 1'b1;
    wait_for_rd();
    cfg_fetch_en = 1'b0;
    wait_for_valid(lat);
    base_acc = n_accept;
    cfg_flush = 1'b1;
    cfg_ready = 1'b1;
    cyc();
    cfg_flush = 1'b0;
    cyc();
    check("flo_state", dbg_state, ST_IDLE);
    check("flo_valid", instr_valid, 0);
    check("flo_no_accept", n_accept - base_acc, 0);
    void'(exp_q.pop_front());

    // Instruction spanning the address wrap
    run_instr(16'hFFFF, 8'h41, 8'h77, 8'h55, 0);

    // Random instructions, addresses and wait states
    for (int i = 0; i < 16; i++) begin
      run_instr(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom_range(0, 3));
    end

    // Asynchronous reset while presenting an instruction
    load_instr(16'h0400, 8'h90, 8'h01, 8'h02, 1'b1, len);
    cfg_waits = 0;
    cfg_ready = 1'b0;
    cfg_fetch_en = 1'b1;
    wait_for_rd();
    cfg_fetch_en = 1'b0;
    wait_for_valid(lat);
    base_inc = n_pc_inc;
    cyc();
    reset = 1'b1;
    #1;
    check("arst_valid",  instr_valid, 0);
    check("arst_state",  dbg_state, ST_IDLE);
    check("arst_opcode", instr_opcode, 0);
    check("arst_op1",    instr_op1, 0);
    check("arst_len",    instr_len, 0);
    check("arst_pc",     instr_pc, 0);
    check("arst_mem_rd", mem_rd, 0);
    exp_q.delete();
    cyc();
    cyc();
    reset = 1'b0;
    cfg_ready = 1'b1;
    cyc();
    check("arst_after_state", dbg_state, ST_IDLE);
    check("arst_no_inc", n_pc_inc - base_inc, 0);
    run_instr(16'h0500, 8'h85, 8'h66, 8'h77, 1);

    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
